// File: rtl/ppu_mix_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ppu_mix_pkg : shared constants and types for the pixel mix sequencer
// Revision    : 1.0
// ---------------------------------------------------------------------------
package ppu_mix_pkg;

  localparam int NUM_PIXELS = 320;
  localparam int ADDR_W     = 9;

  localparam logic [ADDR_W-1:0] LAST_PIXEL = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ENG = 2'd1,
    SWEEP    = 2'd2,
    DRAIN    = 2'd3
  } mix_state_t;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
  } mix_tag_t;

endpackage
`default_nettype wire

// File: rtl/mix_tag_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mix_tag_pipe : RD_LATENCY-deep (valid, addr) delay line with sync flush
// Revision     : 1.0
// ---------------------------------------------------------------------------
module mix_tag_pipe
  import ppu_mix_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic     clk,
  input  logic     flush,
  input  mix_tag_t tag_in,
  output mix_tag_t tag_out
);

  mix_tag_t [RD_LATENCY-1:0] stage;

  always_ff @(posedge clk) begin
    if (flush) begin
      stage <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[RD_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/pixel_mix_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pixel_mix_sequencer : per-scanline sweep of the pixel mixer datapath.
//                       Optional overrun counter: PIXEL_MIX_OVERRUN_CNT_EN
// Revision            : 1.0
// ---------------------------------------------------------------------------
module pixel_mix_sequencer
  import ppu_mix_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int NUM_ENG    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rowbuf_swap,
  input  logic [NUM_ENG-1:0] engines_done,
  output logic [ADDR_W-1:0]  pixel_addr,
  output logic               mix_valid,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic               mix_busy,
  output logic               mix_done
`ifdef PIXEL_MIX_OVERRUN_CNT_EN
  ,
  output logic [15:0]        overrun_cnt
`endif
);

  mix_state_t state;
  mix_tag_t   tag_in;
  mix_tag_t   tag_out;
  logic       overrun;

  // A swap outside IDLE abandons the current line.
  assign overrun = rowbuf_swap && (state != IDLE);

  assign tag_in.vld  = (state == SWEEP);
  assign tag_in.addr = pixel_addr;

  mix_tag_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_tag_pipe (
    .clk    (clk),
    .flush  (reset || overrun),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  assign mix_valid = tag_out.vld;
  assign wr_en     = tag_out.vld;
  assign wr_addr   = tag_out.addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pixel_addr <= '0;
      mix_busy   <= 1'b0;
      mix_done   <= 1'b0;
    end else begin
      mix_done <= 1'b0;
      if (overrun) begin
        state      <= WAIT_ENG;
        pixel_addr <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rowbuf_swap) begin
              state    <= WAIT_ENG;
              mix_busy <= 1'b1;
            end
          end
          WAIT_ENG: begin
            if (&engines_done) begin
              state <= SWEEP;
            end
          end
          SWEEP: begin
            if (pixel_addr == LAST_PIXEL) begin
              state <= DRAIN;
            end else begin
              pixel_addr <= pixel_addr + ADDR_W'(1);
            end
          end
          DRAIN: begin
            // The last column leaving the delay line ends the line.
            if (wr_en && (wr_addr == LAST_PIXEL)) begin
              state      <= IDLE;
              mix_busy   <= 1'b0;
              mix_done   <= 1'b1;
              pixel_addr <= '0;
            end
          end
          default: begin
            state    <= IDLE;
            mix_busy <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PIXEL_MIX_OVERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_cnt <= '0;
    end else if (overrun && (overrun_cnt != 16'hFFFF)) begin
      overrun_cnt <= overrun_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
